uart_rx: RTL and testbench

//   Receives 8N1 serial bytes on uart_rxd and hands each one to the

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_ff.sv | 27 ++
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// No logic: enum for the receive FSM and the clocks-per-bit helper.
// Used by uart_rx; also suitable for a future transmitter.
package uart_pkg;

  // Receive FSM states. PARITY is only visited in the even-parity build.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per bit. The integer divide truncates; at 100 MHz / 115200 this gives 868.
  function automatic int unsigned cpb(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for an asynchronous single-bit input.
// Latency: DEPTH cycles from pin to q.
// No backpressure; q follows d delayed, and reset forces every stage to RST_VAL.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the pin through the chain; reset loads the idle level so no false edge appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {DEPTH{RST_VAL}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_PARITY_EN is defined); one-cycle data_valid per byte.
// Latency: SYNC_DEPTH + CPB/2 + 9*CPB (+CPB with parity) + 1 cycles from start edge to data_valid.
// No backpressure: data_out must be taken in the cycle data_valid is high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int          SYNC_DEPTH = 2
) (
  input  logic       clk_100mhz,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CPB  = cpb(CLK_HZ, BAUD);
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB);

  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic            rx_s;

  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      data_out_nxt;
  logic            data_valid_nxt;
  logic            frame_err_nxt;
  logic            busy_nxt;

`ifdef UART_PARITY_EN
  logic            par_bad, par_bad_nxt;
  logic            parity_err_nxt;
`endif

  sync_ff #(
    .DEPTH   (SYNC_DEPTH),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk_100mhz),
    .rst (sys_rst),
    .d   (uart_rxd),
    .q   (rx_s)
  );

  // Next-state logic: counters, shift register and registered output pulses.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    busy_nxt       = busy;
`ifdef UART_PARITY_EN
    par_bad_nxt    = par_bad;
    parity_err_nxt = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
`ifdef UART_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end

      // Re-check the line half a bit in; a high line here was a glitch, not a start bit.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      // Counter is now phase-aligned to bit centres; shift in LSB first.
      DATA: begin
        if (cnt == CPB_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

`ifdef UART_PARITY_EN
      // Even parity: data bits plus parity bit must hold an even number of ones.
      PARITY: begin
        if (cnt == CPB_LAST) begin
          cnt_nxt     = '0;
          par_bad_nxt = rx_s ^ (^shift);
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif

      // Good stop bit delivers the byte; a low stop bit discards it and waits out the break.
      STOP: begin
        if (cnt == CPB_LAST) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
          if (rx_s) begin
            state_nxt      = IDLE;
            data_out_nxt   = shift;
            data_valid_nxt = 1'b1;
`ifdef UART_PARITY_EN
            parity_err_nxt = par_bad;
`endif
          end else begin
            state_nxt     = BREAK;
            frame_err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      // Hold off until the line returns high so a stuck-low line is not read as 0x00 frames.
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any frame in progress.
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= busy_nxt;
`ifdef UART_PARITY_EN
      par_bad    <= par_bad_nxt;
      parity_err <= parity_err_nxt;
`endif
    end
  end

`ifndef UART_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial stimulus at 115200 baud on a 100 MHz clock.
// Expected bytes/parity flags are queued as frames are driven and compared with captured output.
// Define UART_PARITY_EN for the 8E1 build; the parity scenario then runs too.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 868;
  localparam int HALF = 434;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam int LAT_EXP = 2 + HALF + 10 * CPB + 1;
`else
  localparam bit PAR_EN  = 1'b0;
  localparam int LAT_EXP = 2 + HALF + 9 * CPB + 1;
`endif

  logic       clk_100mhz = 1'b0;
  logic       sys_rst    = 1'b1;
  logic       uart_rxd   = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(
    .CLK_HZ     (100_000_000),
    .BAUD       (115200),
    .SYNC_DEPTH (2)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .sys_rst    (sys_rst),
    .uart_rxd   (uart_rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard: expectations pushed by the driver, observations pushed by the monitor.
  logic [7:0] exp_q[$];
  logic       exp_pe_q[$];
  logic [7:0] obs_q[$];
  logic       obs_pe_q[$];

  int dv_cnt    = 0;
  int fe_cnt    = 0;
  int both_cnt  = 0;
  int stray_pe  = 0;
  int t_dv      = -1;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Monitor samples on the falling edge, away from DUT updates.
  always @(negedge clk_100mhz) begin
    if (data_valid) begin
      obs_q.push_back(data_out);
      obs_pe_q.push_back(parity_err);
      dv_cnt = dv_cnt + 1;
      t_dv   = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (data_valid && frame_err) both_cnt = both_cnt + 1;
    if (parity_err && !data_valid) stray_pe = stray_pe + 1;
  end

  // Drive one frame; the line is left at the stop-bit level. Good frames queue expectations.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      exp_pe_q.push_back(PAR_EN && (par != ^b));
    end
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk_100mhz);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk_100mhz);
    end
    if (PAR_EN) begin
      uart_rxd = par;
      repeat (CPB) @(negedge clk_100mhz);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk_100mhz);
  endtask

  task automatic test_reset;
    sys_rst  = 1'b1;
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk_100mhz);
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk_100mhz);
    sys_rst = 1'b0;
    repeat (20) @(negedge clk_100mhz);
  endtask

  task automatic test_back_to_back;
    int f0;
    logic [7:0] e, o;
    logic ep, op;
    f0 = fe_cnt;
    send_frame(8'h55, ^8'h55, 1'b1);
    send_frame(8'hA3, ^8'hA3, 1'b1);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk_100mhz);
    checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ep = exp_pe_q.pop_front(); op = obs_pe_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL b2b_data got %h want %h", o, e); end
      checks++; if (op !== ep) begin failures++; $display("FAIL b2b_parity got %b want %b", op, ep); end
    end
    exp_q.delete(); exp_pe_q.delete(); obs_q.delete(); obs_pe_q.delete();
    checks++; if (fe_cnt !== f0) begin failures++; $display("FAIL b2b_frame_err got %0d want %0d", fe_cnt, f0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = dv_cnt; f0 = fe_cnt;
    uart_rxd = 1'b0;
    repeat (300) @(negedge clk_100mhz);
    uart_rxd = 1'b1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got %b want 1", busy); end
    repeat (140) @(negedge clk_100mhz);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop got %b want 0", busy); end
    repeat (CPB) @(negedge clk_100mhz);
    checks++; if (dv_cnt !== d0) begin failures++; $display("FAIL glitch_no_valid got %0d want %0d", dv_cnt, d0); end
    checks++; if (fe_cnt !== f0) begin failures++; $display("FAIL glitch_no_frame_err got %0d want %0d", fe_cnt, f0); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (2000) @(negedge clk_100mhz);
    checks++; if (fe_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_pulse got %0d want %0d", fe_cnt, f0 + 1); end
    checks++; if (data_out !== 8'hA3) begin failures++; $display("FAIL ferr_data_kept got %h want a3", data_out); end
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk_100mhz);
    checks++; if (fe_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_single got %0d want %0d", fe_cnt, f0 + 1); end
    checks++; if (dv_cnt !== d0) begin failures++; $display("FAIL ferr_no_valid got %0d want %0d", dv_cnt, d0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    logic [7:0] e, o;
    logic ep, op;
    d0 = dv_cnt;
    // 0xFF: start bit low, all data bits high; reset lands in the middle of bit 4.
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk_100mhz);
    uart_rxd = 1'b1;
    repeat (4 * CPB + HALF) @(negedge clk_100mhz);
    sys_rst = 1'b1;
    @(negedge clk_100mhz);
    sys_rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL midrst_data_out got %h want 00", data_out); end
    repeat (6 * CPB) @(negedge clk_100mhz);
    checks++; if (dv_cnt !== d0) begin failures++; $display("FAIL midrst_garbage got %0d want %0d", dv_cnt, d0); end
    send_frame(8'h81, ^8'h81, 1'b1);
    repeat (20) @(negedge clk_100mhz);
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL midrst_count got %0d want 1", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ep = exp_pe_q.pop_front(); op = obs_pe_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL midrst_data got %h want %h", o, e); end
      checks++; if (op !== ep) begin failures++; $display("FAIL midrst_parity got %b want %b", op, ep); end
    end
    exp_q.delete(); exp_pe_q.delete(); obs_q.delete(); obs_pe_q.delete();
  endtask

  task automatic test_latency;
    int t0, lat;
    logic [7:0] e, o;
    logic ep, op;
    t_dv = -1;
    t0 = cyc;
    send_frame(8'h00, ^8'h00, 1'b1);
    repeat (20) @(negedge clk_100mhz);
    lat = t_dv - t0;
    checks++; if (lat < LAT_EXP - 1 || lat > LAT_EXP + 1) begin failures++; $display("FAIL latency got %0d want %0d+/-1", lat, LAT_EXP); end
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL latency_count got %0d want 1", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ep = exp_pe_q.pop_front(); op = obs_pe_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL latency_data got %h want %h", o, e); end
      checks++; if (op !== ep) begin failures++; $display("FAIL latency_parity got %b want %b", op, ep); end
    end
    exp_q.delete(); exp_pe_q.delete(); obs_q.delete(); obs_pe_q.delete();
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] e, o;
    logic ep, op;
    send_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk_100mhz);
    checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL parity_count got %0d want 2", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ep = exp_pe_q.pop_front(); op = obs_pe_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL parity_data got %h want %h", o, e); end
      checks++; if (op !== ep) begin failures++; $display("FAIL parity_flag got %b want %b", op, ep); end
    end
    exp_q.delete(); exp_pe_q.delete(); obs_q.delete(); obs_pe_q.delete();
  endtask
`endif

  task automatic test_invariants;
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL valid_and_ferr_overlap got %0d want 0", both_cnt); end
    checks++; if (stray_pe !== 0) begin failures++; $display("FAIL stray_parity_err got %0d want 0", stray_pe); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_latency();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
